// File: rtl/fg_prog_pkg.sv
// Shared types and default widths for the floating-gate programming sequencer.
package fg_prog_pkg;

    localparam int unsigned DEF_COL_BITS  = 6;
    localparam int unsigned DEF_ROW_BITS  = 5;
    localparam int unsigned DEF_ISL_BITS  = 2;
    localparam int unsigned DEF_SETUP_CYC = 8;
    localparam int unsigned DEF_PW_BITS   = 16;
    localparam int unsigned DEF_NP_BITS   = 8;

    typedef enum logic [1:0] {
        OP_INJECT  = 2'b00,
        OP_TUNNEL  = 2'b01,
        OP_SELECT  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        GAP     = 3'd3,
        RECOVER = 3'd4
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter with a zero flag; shared by settle and pulse-width timing.
module fg_prog_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (load)          cnt <= load_val;
        else if (cnt != '0)     cnt <= cnt - W'(1);
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: latches one command and drives decoder address, run/prog
// and break-before-make timed pulses. Define FG_PROG_ABORT_EN to add abort/aborted ports.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int unsigned COL_BITS  = DEF_COL_BITS,
    parameter int unsigned ROW_BITS  = DEF_ROW_BITS,
    parameter int unsigned ISL_BITS  = DEF_ISL_BITS,
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PW_BITS   = DEF_PW_BITS,
    parameter int unsigned NP_BITS   = DEF_NP_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ISL_BITS-1:0] cmd_island,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [PW_BITS-1:0]  cmd_pw,
    input  logic [NP_BITS-1:0]  cmd_np,
    output logic [ISL_BITS-1:0] dec_island,
    output logic [ROW_BITS-1:0] dec_row,
    output logic [COL_BITS-1:0] dec_col,
    output logic                run,
    output logic                prog,
    output logic                drain_en,
    output logic                vtun_en,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef FG_PROG_ABORT_EN
   ,input  logic                abort,
    output logic                aborted
`endif
);

    localparam int unsigned SET_BITS = $clog2(SETUP_CYC + 1);
    localparam int unsigned TW       = max_u(PW_BITS, SET_BITS);

    state_e               state, state_nx;
    op_e                  op_q;
    logic [PW_BITS-1:0]   pw_q;
    logic [NP_BITS-1:0]   rem_q, rem_nx;
    logic                 tmr_load, tmr_zero;
    logic [TW-1:0]        tmr_val, setup_ld, pulse_ld;
    logic                 accept, legal_acc;

    logic [ISL_BITS-1:0]  dec_island_nx;
    logic [ROW_BITS-1:0]  dec_row_nx;
    logic [COL_BITS-1:0]  dec_col_nx;
    logic                 run_nx, prog_nx, drain_nx, vtun_nx, busy_nx, done_nx, err_nx;
`ifdef FG_PROG_ABORT_EN
    logic                 ab_q, ab_nx, aborted_nx;
`endif

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign legal_acc = accept && (op_e'(cmd_op) != OP_ILLEGAL);
    assign setup_ld  = TW'(SETUP_CYC - 1);
    // A zero pulse width still yields a one-cycle pulse.
    assign pulse_ld  = (pw_q == '0) ? '0 : TW'(pw_q) - TW'(1);

    fg_prog_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = setup_ld;
        rem_nx   = rem_q;
`ifdef FG_PROG_ABORT_EN
        ab_nx    = ab_q;
`endif
        case (state)
            IDLE: begin
                if (legal_acc) begin
                    state_nx = SETUP;
                    tmr_load = 1'b1;
                    rem_nx   = cmd_np;
`ifdef FG_PROG_ABORT_EN
                    ab_nx    = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (op_q == OP_SELECT || rem_q == '0) begin
                        state_nx = RECOVER;
                    end else begin
                        state_nx = PULSE;
                        tmr_val  = pulse_ld;
                    end
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_nx = GAP;
                    tmr_load = 1'b1;
                    rem_nx   = rem_q - NP_BITS'(1);
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (rem_q != '0) begin
                        state_nx = PULSE;
                        tmr_val  = pulse_ld;
                    end else begin
                        state_nx = RECOVER;
                    end
                end
            end
            RECOVER: begin
                if (tmr_zero) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
`ifdef FG_PROG_ABORT_EN
        // Abort overrides any phase transition; RECOVER still runs its full settle time.
        if (abort && (state == SETUP || state == PULSE || state == GAP)) begin
            state_nx = RECOVER;
            tmr_load = 1'b1;
            tmr_val  = setup_ld;
            ab_nx    = 1'b1;
        end
`endif
    end

    // Registered outputs derive from the next state so enables never lead the address change.
    always_comb begin
        run_nx        = (state_nx == IDLE);
        prog_nx       = (state_nx == SETUP) || (state_nx == PULSE) || (state_nx == GAP);
        drain_nx      = (state_nx == PULSE) && (op_q == OP_INJECT);
        vtun_nx       = (state_nx == PULSE) && (op_q == OP_TUNNEL);
        busy_nx       = (state_nx != IDLE);
        done_nx       = (state == RECOVER) && (state_nx == IDLE);
        err_nx        = accept && (op_e'(cmd_op) == OP_ILLEGAL);
        dec_island_nx = legal_acc ? cmd_island : dec_island;
        dec_row_nx    = legal_acc ? cmd_row    : dec_row;
        dec_col_nx    = legal_acc ? cmd_col    : dec_col;
`ifdef FG_PROG_ABORT_EN
        aborted_nx    = done_nx && ab_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_INJECT;
            pw_q  <= '0;
            rem_q <= '0;
`ifdef FG_PROG_ABORT_EN
            ab_q  <= 1'b0;
`endif
        end else begin
            if (legal_acc) begin
                op_q <= op_e'(cmd_op);
                pw_q <= cmd_pw;
            end
            rem_q <= rem_nx;
`ifdef FG_PROG_ABORT_EN
            ab_q  <= ab_nx;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run        <= 1'b1;
            prog       <= 1'b0;
            drain_en   <= 1'b0;
            vtun_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            dec_island <= '0;
            dec_row    <= '0;
            dec_col    <= '0;
`ifdef FG_PROG_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            run        <= run_nx;
            prog       <= prog_nx;
            drain_en   <= drain_nx;
            vtun_en    <= vtun_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            err        <= err_nx;
            dec_island <= dec_island_nx;
            dec_row    <= dec_row_nx;
            dec_col    <= dec_col_nx;
`ifdef FG_PROG_ABORT_EN
            aborted    <= aborted_nx;
`endif
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Self-checking bench for fg_prog_sequencer: directed vector table, hand-written corner
// sequences and random commands against a timeline model of the pulse schedule.
module tb_fg_prog_sequencer;

    localparam int S = 8;

    logic        clk, reset, cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_island;
    logic [4:0]  cmd_row;
    logic [5:0]  cmd_col;
    logic [15:0] cmd_pw;
    logic [7:0]  cmd_np;
    logic [1:0]  dec_island;
    logic [4:0]  dec_row;
    logic [5:0]  dec_col;
    logic        run, prog, drain_en, vtun_en, busy, done, err;
`ifdef FG_PROG_ABORT_EN
    logic        abort, aborted;
`endif

    int checks = 0;
    int errors = 0;
    int last_isl = 0, last_row = 0, last_col = 0;

    typedef struct {
        int done_off, done_cnt, pulses, first_en, drain_cyc, vtun_cyc, wave_bad, wave_first, dec_bad;
    } meas_t;

    typedef struct {
        int op, isl, row, col, pw, np;
        int e_done, e_pulses, e_drain, e_vtun, e_first;
    } vec_t;

    vec_t tbl[6];

    fg_prog_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_island (cmd_island),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_pw     (cmd_pw),
        .cmd_np     (cmd_np),
        .dec_island (dec_island),
        .dec_row    (dec_row),
        .dec_col    (dec_col),
        .run        (run),
        .prog       (prog),
        .drain_en   (drain_en),
        .vtun_en    (vtun_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef FG_PROG_ABORT_EN
       ,.abort      (abort),
        .aborted    (aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model, offsets counted from the first cycle after accept.
    function automatic int pw_eff(input int pw);
        return (pw == 0) ? 1 : pw;
    endfunction
    function automatic int n_pulses(input int op, input int np);
        return (op == 2) ? 0 : np;
    endfunction
    function automatic int done_at(input int op, input int pw, input int np);
        return 2 * S + n_pulses(op, np) * (pw_eff(pw) + S);
    endfunction
    function automatic bit pulse_at(input int op, input int pw, input int np, input int off);
        int per, rel;
        if (n_pulses(op, np) == 0 || off < S) return 1'b0;
        per = pw_eff(pw) + S;
        rel = off - S;
        return ((rel / per) < n_pulses(op, np)) && ((rel % per) < pw_eff(pw));
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((drain_en && vtun_en) || ((drain_en || vtun_en) && !(prog && !run))) begin
                errors++;
                $display("FAIL enable_invariant: drain_en=%0b vtun_en=%0b prog=%0b run=%0b, required one enable at most and only with prog=1 run=0",
                         drain_en, vtun_en, prog, run);
            end
        end
    end

    task automatic run_cmd(input int op, input int isl, input int row, input int col,
                           input int pw, input int np, output meas_t m);
        int  dn;
        bit  ed, ev, en, prev_en;
        m.done_off = -1; m.done_cnt = 0; m.pulses = 0; m.first_en = -1;
        m.drain_cyc = 0; m.vtun_cyc = 0; m.wave_bad = 0; m.wave_first = -1; m.dec_bad = 0;
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_op = 2'(op); cmd_island = 2'(isl); cmd_row = 5'(row); cmd_col = 6'(col);
        cmd_pw = 16'(pw); cmd_np = 8'(np); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        last_isl = isl; last_row = row; last_col = col;
        dn = done_at(op, pw, np);
        prev_en = 1'b0;
        for (int off = 0; off <= dn + 2; off++) begin
            ed = (op == 0) && pulse_at(op, pw, np, off);
            ev = (op == 1) && pulse_at(op, pw, np, off);
            if (drain_en !== ed || vtun_en !== ev || prog !== (off < dn - S) ||
                run !== (off >= dn) || busy !== (off < dn) || done !== (off == dn) || err !== 1'b0) begin
                if (m.wave_bad == 0) m.wave_first = off;
                m.wave_bad++;
            end
            if (dec_island !== 2'(isl) || dec_row !== 5'(row) || dec_col !== 6'(col)) m.dec_bad++;
            en = drain_en | vtun_en;
            if (en && !prev_en) begin
                m.pulses++;
                if (m.first_en < 0) m.first_en = off;
            end
            prev_en = en;
            m.drain_cyc += int'(drain_en);
            m.vtun_cyc  += int'(vtun_en);
            if (done) begin
                m.done_cnt++;
                if (m.done_off < 0) m.done_off = off;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_meas(input string tag, input meas_t m, input int e_done, input int e_pulses,
                              input int e_drain, input int e_vtun, input int e_first);
        chk({tag, "_done_offset"}, m.done_off, e_done);
        chk({tag, "_done_count"}, m.done_cnt, 1);
        chk({tag, "_pulse_count"}, m.pulses, e_pulses);
        chk({tag, "_drain_cycles"}, m.drain_cyc, e_drain);
        chk({tag, "_vtun_cycles"}, m.vtun_cyc, e_vtun);
        chk({tag, "_first_pulse"}, m.first_en, e_first);
        chk($sformatf("%s_wave_mismatch_cycles(first_at_%0d)", tag, m.wave_first), m.wave_bad, 0);
        chk({tag, "_dec_stable"}, m.dec_bad, 0);
    endtask

    initial begin
        meas_t m;
        int    op, pw, np, n, bad, dcnt;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_island = '0; cmd_row = '0;
        cmd_col = '0; cmd_pw = '0; cmd_np = '0;
`ifdef FG_PROG_ABORT_EN
        abort = 1'b0;
`endif
        //         op isl row col  pw  np  done  pulses drain vtun first
        tbl[0] = '{0,  1,  3, 17,  4,  3,   52,     3,   12,   0,   8};
        tbl[1] = '{1,  2, 10, 40,  0,  2,   34,     2,    0,   2,   8};
        tbl[2] = '{2,  3, 31, 63,  7,  5,   16,     0,    0,   0,  -1};
        tbl[3] = '{0,  0,  5,  9,  5,  0,   16,     0,    0,   0,  -1};
        tbl[4] = '{0,  0,  0,  0,  1,  1,   25,     1,    1,   0,   8};
        tbl[5] = '{1,  3, 31, 63,  3, 255, 2821,  255,    0, 765,   8};

        repeat (3) @(negedge clk);
        chk("ready_during_reset", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_run", run, 1);
        chk("rst_prog", prog, 0);
        chk("rst_enables", {drain_en, vtun_en}, 0);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_dec", {dec_island, dec_row, dec_col}, 0);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].op, tbl[i].isl, tbl[i].row, tbl[i].col, tbl[i].pw, tbl[i].np, m);
            check_meas($sformatf("vec%0d", i), m, tbl[i].e_done, tbl[i].e_pulses,
                       tbl[i].e_drain, tbl[i].e_vtun, tbl[i].e_first);
        end

        for (int i = 0; i < 25; i++) begin
            op = int'($urandom_range(0, 2));
            pw = int'($urandom_range(0, 6));
            np = int'($urandom_range(0, 4));
            n  = n_pulses(op, np);
            run_cmd(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 63)), pw, np, m);
            check_meas($sformatf("rand%0d", i), m, done_at(op, pw, np), n,
                       (op == 0) ? n * pw_eff(pw) : 0, (op == 1) ? n * pw_eff(pw) : 0,
                       (n > 0) ? S : -1);
        end

        // Illegal op: err strobe only, address and mode untouched.
        @(negedge clk);
        cmd_op = 2'b11; cmd_island = 2'((last_isl + 1) % 4); cmd_row = 5'((last_row + 1) % 32);
        cmd_col = 6'((last_col + 1) % 64); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("illegal_err", err, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_run_prog", {run, prog}, 2'b10);
        chk("illegal_dec_row", dec_row, last_row);
        chk("illegal_dec_col", dec_col, last_col);
        chk("illegal_ready", cmd_ready, 1);
        @(negedge clk);
        chk("illegal_err_one_cycle", err, 0);

        // cmd_valid held through a busy SELECT: second command waits for cmd_ready.
        @(negedge clk);
        cmd_op = 2'b10; cmd_island = 2'd1; cmd_row = 5'd4; cmd_col = 6'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_island = 2'd2; cmd_row = 5'd6; cmd_col = 6'd8;
        bad = 0;
        for (int off = 0; off <= 2 * S; off++) begin
            if (off < 2 * S) begin
                if (cmd_ready !== 1'b0 || dec_island !== 2'd1 || dec_row !== 5'd4 || dec_col !== 6'd5) bad++;
            end else begin
                chk("hold_ready_at_done", cmd_ready, 1);
                chk("hold_done", done, 1);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("hold_ignored_while_busy", bad, 0);
        chk("hold_second_dec", {dec_island, dec_row, dec_col}, {2'd2, 5'd6, 6'd8});
        chk("hold_second_busy", busy, 1);
        repeat (2 * S) @(negedge clk);
        chk("hold_second_done", done, 1);
        @(negedge clk);

        // Reset in the middle of a pulse: enables drop before the next clock edge.
        cmd_op = 2'b00; cmd_island = 2'd2; cmd_row = 5'd9; cmd_col = 6'd11;
        cmd_pw = 16'd20; cmd_np = 8'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (S + 3) @(negedge clk);
        chk("pre_reset_drain", drain_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_drain", drain_en, 0);
        chk("async_reset_run_prog", {run, prog}, 2'b10);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_dec", {dec_island, dec_row, dec_col}, 0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (60) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        chk("reset_no_done", dcnt, 0);
        chk("reset_idle", {busy, cmd_ready}, 2'b01);

`ifdef FG_PROG_ABORT_EN
        // Abort ignored while idle.
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_ignored", {busy, done, aborted}, 0);
        // Abort during the first gap of INJECT pw=2 np=3 (gap spans offsets 10..17).
        cmd_op = 2'b00; cmd_island = 2'd1; cmd_row = 5'd2; cmd_col = 6'd3;
        cmd_pw = 16'd2; cmd_np = 8'd3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        m.done_off = -1; m.done_cnt = 0; m.drain_cyc = 0; bad = 0; dcnt = 0;
        for (int off = 0; off < 40; off++) begin
            if (off == 11) abort = 1'b1;
            if (off == 12) begin
                abort = 1'b0;
                chk("abort_prog_dropped", prog, 0);
            end
            m.drain_cyc += int'(drain_en);
            dcnt += int'(aborted);
            if (done) begin
                m.done_cnt++;
                if (m.done_off < 0) m.done_off = off;
                if (aborted !== 1'b1) bad++;
            end
            @(negedge clk);
        end
        chk("abort_done_offset", m.done_off, 20);
        chk("abort_done_count", m.done_cnt, 1);
        chk("abort_aborted_with_done", bad, 0);
        chk("abort_aborted_count", dcnt, 1);
        chk("abort_drain_cycles", m.drain_cyc, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
